xgmii_rx_rate_ctrl: RTL and testbench
=====================================

# xgmii_rx_rate_ctrl

Write-side rate-matching and overflow controller for the XGMII clock-crossing FIFO. It sits on the write clock between the MAC/PCS receive stream and the FIFO write port. It gates every FIFO write, deletes surplus idle columns between frames when the FIFO is filling, and never splits a frame. If a frame cannot be stored, it truncates that frame and poisons it with an error column.

## Interface
Parameters:
- LEVEL_W, 5, width of the FIFO fill-level input
- HIGH_MARK, 12, fill level at or above which idle columns may be deleted
- FULL_MARK, 15, fill level at or above which no word may be written
- MIN_IPG, 1, idle columns that must be written after a terminate before any idle is deleted (1..15)

Ports:
- wr_clk  in  1  write-domain clock (one clock; whole block synchronous to it)
- wr_rst  in  1  reset, asynchronous, active-high
- in_data  in  64  XGMII data, lane 0 = bits [7:0]
- in_ctrl  in  8  XGMII control, bit n for lane n
- fifo_level  in  LEVEL_W  FIFO write-side fill count, sampled every cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  64  data word to FIFO
- fifo_wr_ctrl  out  8  control word to FIFO
- in_frame  out  1  high while state is FRAME
- drop_count  out  16  deleted idle columns, saturating
- overflow_count  out  16  frames truncated, saturating

## Operation
- Classification is combinational on the inputs:
  - idle = in_ctrl==8'hff and every byte is 8'h07
  - start = (in_ctrl[0] and byte0==8'hFB) or (in_ctrl[4] and byte4==8'hFB)
  - term = any lane n with in_ctrl[n] and byte n==8'hFD
- full = fifo_level>=FULL_MARK; high = fifo_level>=HIGH_MARK.
- idle_run: 4-bit counter, saturates at 15. It clears on a write of a word containing term and increments on each idle written in IDLE.
- States: IDLE, FRAME, DISCARD, POISON.
- IDLE:
  - start and !full: write, go to FRAME. A start+term in the same word writes and stays in IDLE.
  - start and full: drop, overflow_count++, go to DISCARD.
  - idle and high and idle_run>=MIN_IPG: drop, drop_count++.
  - idle and full (deletion not allowed): drop, drop_count++.
  - any other word: write if !full, else drop with drop_count++.
- FRAME:
  - !full: write. If term, go to IDLE.
  - full: drop, overflow_count++. If term, go to POISON; else go to DISCARD.
- DISCARD: drop every word. On term, go to POISON.
- POISON:
  - If !full: write an error column (data 64'hFEFE_FEFE_FEFE_FEFE, ctrl 8'hff) in place of the input word, go to IDLE.
  - Else drop and stay.
  - If the input word in POISON is a start, that frame is also lost: overflow_count++, go to DISCARD after the poison write, or stay in POISON if still full.
- Counters saturate at 16'hFFFF and do not wrap.
- Idle deletion occurs only in IDLE. Words inside a frame are never deleted for rate matching.

## Timing
- All outputs are registered. Latency from in_data/in_ctrl to fifo_wr_data/fifo_wr_ctrl is 1 cycle.
- fifo_wr_en is asserted in the cycle after the accepted input word.
- The decision uses fifo_level from the same cycle as the input word. The FIFO must tolerate one extra write beyond FULL_MARK; FULL_MARK is set at least 1 below true depth.
- When fifo_wr_en=0, fifo_wr_data/ctrl hold the idle column (64'h0707070707070707 / 8'hff).
- Reset values:
  - fifo_wr_en=0, fifo_wr_data=64'h0707070707070707, fifo_wr_ctrl=8'hff
  - in_frame=0, drop_count=0, overflow_count=0, idle_run=0, state IDLE
- Reset asserted mid-frame aborts immediately with no poison column; after release the block waits in IDLE for the next start.
- Back-to-back frames (term word followed by a start word) are legal. With idle_run<MIN_IPG no idle can be deleted, but the start is still written.

## Test plan
- Pass-through:
  - Stimulus: fifo_level=0, 10 idles, start word (ctrl 8'h01, data ..FB), 6 data words, term word (ctrl 8'h80, byte7 FD).
  - Response: each word appears 1 cycle later with fifo_wr_en=1, drop_count=0, in_frame high for the frame words only.
- Idle deletion:
  - Stimulus: fifo_level=12, frame of 4 words, then 5 idles.
  - Response: the first idle after term is written (MIN_IPG=1) and the next 4 are dropped; drop_count=4.
- Mid-frame overflow:
  - Stimulus: fifo_level raised to 15 on the 3rd word of an 8-word frame, lowered to 3 before term.
  - Response: words 3..term are dropped, overflow_count=1, one FE error column is written the cycle after term, then state is IDLE.
- Start while full:
  - Stimulus: fifo_level=15 on a start word.
  - Response: the whole frame is discarded, overflow_count=1, error column written once the level drops.
- Saturation:
  - Stimulus: force drop_count near 16'hFFFF via 70000 deletable idles at fifo_level=14.
  - Response: drop_count holds at 16'hFFFF.
- Async reset mid-frame:
  - Stimulus: wr_rst pulsed off-edge during a frame.
  - Response: all outputs take reset values immediately, no poison column, next start is written normally.

Source files
------------

// File: rtl/xgmii_rx_rate_ctrl.sv
// Write-side rate matcher for the XGMII rx clock-crossing FIFO: gates writes, deletes
// surplus inter-frame idles when the FIFO runs high, truncates and poisons frames on overflow.
module xgmii_rx_rate_ctrl #(
  parameter int unsigned LEVEL_W   = 5,
  parameter int unsigned HIGH_MARK = 12,
  parameter int unsigned FULL_MARK = 15,
  parameter int unsigned MIN_IPG   = 1
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic [63:0]        in_data,
  input  logic [7:0]         in_ctrl,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_wr_en,
  output logic [63:0]        fifo_wr_data,
  output logic [7:0]         fifo_wr_ctrl,
  output logic               in_frame,
  output logic [15:0]        drop_count,
  output logic [15:0]        overflow_count
);

  localparam logic [63:0]        IdleData = 64'h0707_0707_0707_0707;
  localparam logic [63:0]        ErrData  = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [7:0]         AllCtrl  = 8'hff;
  localparam logic [LEVEL_W-1:0] HighLvl  = LEVEL_W'(HIGH_MARK);
  localparam logic [LEVEL_W-1:0] FullLvl  = LEVEL_W'(FULL_MARK);
  localparam logic [3:0]         MinIpg   = 4'(MIN_IPG);

  typedef enum logic [1:0] {StIdle, StFrame, StDiscard, StPoison} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idle_run_q;
  logic        wr_en_q;
  logic [63:0] wr_data_q;
  logic [7:0]  wr_ctrl_q;
  logic        in_frame_q;
  logic [15:0] drop_cnt_q;
  logic [15:0] ovf_cnt_q;

  logic is_idle, is_start, is_term;
  logic full, high;
  logic wr_in, wr_err, drop_inc, ovf_inc, run_clr, run_inc;

  // Word classification
  always_comb begin
    is_idle  = (in_ctrl == AllCtrl) && (in_data == IdleData);
    is_start = (in_ctrl[0] && (in_data[7:0] == 8'hFB)) ||
               (in_ctrl[4] && (in_data[39:32] == 8'hFB));
    is_term  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (in_ctrl[n] && (in_data[8*n +: 8] == 8'hFD)) is_term = 1'b1;
    end
  end

  assign full = (fifo_level >= FullLvl);
  assign high = (fifo_level >= HighLvl);

  always_comb begin
    state_d  = state_q;
    wr_in    = 1'b0;
    wr_err   = 1'b0;
    drop_inc = 1'b0;
    ovf_inc  = 1'b0;
    run_clr  = 1'b0;
    run_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_start && !full) begin
          wr_in   = 1'b1;
          run_clr = is_term;
          state_d = is_term ? StIdle : StFrame;
        end else if (is_start) begin
          // A start+term word that cannot be stored ends its own frame at once.
          ovf_inc = 1'b1;
          state_d = is_term ? StPoison : StDiscard;
        end else if (is_idle && high && (idle_run_q >= MinIpg)) begin
          drop_inc = 1'b1;
        end else if (full) begin
          drop_inc = 1'b1;
        end else begin
          wr_in   = 1'b1;
          run_inc = is_idle;
          run_clr = is_term;
        end
      end
      StFrame: begin
        if (!full) begin
          wr_in = 1'b1;
          if (is_term) begin
            run_clr = 1'b1;
            state_d = StIdle;
          end
        end else begin
          ovf_inc = 1'b1;
          state_d = is_term ? StPoison : StDiscard;
        end
      end
      StDiscard: begin
        if (is_term) state_d = StPoison;
      end
      StPoison: begin
        // A start arriving here belongs to a frame that is already lost.
        ovf_inc = is_start;
        if (!full) begin
          wr_err  = 1'b1;
          state_d = is_start ? StDiscard : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q    <= StIdle;
      idle_run_q <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= IdleData;
      wr_ctrl_q  <= AllCtrl;
      in_frame_q <= 1'b0;
      drop_cnt_q <= 16'd0;
      ovf_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      in_frame_q <= (state_d == StFrame);
      wr_en_q    <= wr_in | wr_err;
      if (wr_in) begin
        wr_data_q <= in_data;
        wr_ctrl_q <= in_ctrl;
      end else if (wr_err) begin
        wr_data_q <= ErrData;
        wr_ctrl_q <= AllCtrl;
      end else begin
        wr_data_q <= IdleData;
        wr_ctrl_q <= AllCtrl;
      end
      if (run_clr) begin
        idle_run_q <= 4'd0;
      end else if (run_inc && (idle_run_q != 4'hf)) begin
        idle_run_q <= idle_run_q + 4'd1;
      end
      if (drop_inc && (drop_cnt_q != 16'hffff)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (ovf_inc && (ovf_cnt_q != 16'hffff)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_data   = wr_data_q;
  assign fifo_wr_ctrl   = wr_ctrl_q;
  assign in_frame       = in_frame_q;
  assign drop_count     = drop_cnt_q;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_rate_ctrl.sv
// Self-checking bench for xgmii_rx_rate_ctrl: vector tables fed through a scoreboard queue,
// plus hand-written reset and saturation sequences.
module tb_xgmii_rx_rate_ctrl;

  localparam int unsigned LW = 5;
  localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
  localparam logic [63:0] ERR_D  = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [63:0] START_D  = 64'hD555_5555_5555_55FB;
  localparam logic [7:0]  START_C  = 8'h01;
  localparam logic [63:0] START4_D = 64'h5555_55FB_0707_0707;
  localparam logic [7:0]  START4_C = 8'h1F;
  localparam logic [63:0] TERM_D   = 64'hFD00_1122_3344_5566;
  localparam logic [7:0]  TERM_C   = 8'h80;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic [63:0]   in_data = IDLE_D;
  logic [7:0]    in_ctrl = 8'hff;
  logic [LW-1:0] fifo_level = '0;
  logic          fifo_wr_en;
  logic [63:0]   fifo_wr_data;
  logic [7:0]    fifo_wr_ctrl;
  logic          in_frame;
  logic [15:0]   drop_count;
  logic [15:0]   overflow_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]   d;
    logic [7:0]    c;
    logic [LW-1:0] lvl;
    logic          en;
    logic [63:0]   ed;
    logic [7:0]    ec;
    logic          fr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  xgmii_rx_rate_ctrl #(
    .LEVEL_W(LW), .HIGH_MARK(12), .FULL_MARK(15), .MIN_IPG(1)
  ) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .in_data        (in_data),
    .in_ctrl        (in_ctrl),
    .fifo_level     (fifo_level),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_wr_ctrl   (fifo_wr_ctrl),
    .in_frame       (in_frame),
    .drop_count     (drop_count),
    .overflow_count (overflow_count)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dword(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h1234_5600 + 32'(i)};
  endfunction

  function automatic void add(input logic [63:0] d, input logic [7:0] c, input int lvl,
                              input logic en, input logic [63:0] ed, input logic [7:0] ec,
                              input logic fr);
    vec_t v;
    v.d = d; v.c = c; v.lvl = LW'(lvl); v.en = en; v.ed = ed; v.ec = ec; v.fr = fr;
    vecs.push_back(v);
  endfunction

  // Expected outcomes: written through, dropped, or replaced by the error column.
  function automatic void add_wr(input logic [63:0] d, input logic [7:0] c, input int lvl,
                                 input logic fr);
    add(d, c, lvl, 1'b1, d, c, fr);
  endfunction
  function automatic void add_dr(input logic [63:0] d, input logic [7:0] c, input int lvl,
                                 input logic fr);
    add(d, c, lvl, 1'b0, IDLE_D, 8'hff, fr);
  endfunction
  function automatic void add_err(input logic [63:0] d, input logic [7:0] c, input int lvl);
    add(d, c, lvl, 1'b1, ERR_D, 8'hff, 1'b0);
  endfunction

  task automatic check_pending();
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wr_en",    64'(fifo_wr_en),   64'(e.en));
      chk("wr_data",  fifo_wr_data,      e.ed);
      chk("wr_ctrl",  64'(fifo_wr_ctrl), 64'(e.ec));
      chk("in_frame", 64'(in_frame),     64'(e.fr));
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge wr_clk);
    check_pending();
    in_data    = v.d;
    in_ctrl    = v.c;
    fifo_level = v.lvl;
    sb.push_back(v);
  endtask

  task automatic flush();
    @(negedge wr_clk);
    check_pending();
    in_data    = IDLE_D;
    in_ctrl    = 8'hff;
    fifo_level = '0;
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    flush();
    vecs.delete();
  endtask

  task automatic do_reset();
    in_data    = IDLE_D;
    in_ctrl    = 8'hff;
    fifo_level = '0;
    wr_rst     = 1'b1;
    sb.delete();
    @(negedge wr_clk);
    @(negedge wr_clk);
    wr_rst = 1'b0;
  endtask

  task automatic chk_counts(input string tag, input logic [15:0] dc, input logic [15:0] oc);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(dc));
    chk({tag, "_overflow_count"}, 64'(overflow_count), 64'(oc));
  endtask

  initial begin
    @(negedge wr_clk);
    chk("reset_wr_en",   64'(fifo_wr_en),   64'd0);
    chk("reset_wr_data", fifo_wr_data,      IDLE_D);
    chk("reset_wr_ctrl", 64'(fifo_wr_ctrl), 64'hff);
    chk("reset_in_frame", 64'(in_frame),    64'd0);
    chk_counts("reset", 16'd0, 16'd0);
    do_reset();

    // Pass-through at empty FIFO
    for (int i = 0; i < 10; i++) add_wr(IDLE_D, 8'hff, 0, 1'b0);
    add_wr(START_D, START_C, 0, 1'b1);
    for (int i = 0; i < 6; i++) add_wr(dword(i), 8'h00, 0, 1'b1);
    add_wr(TERM_D, TERM_C, 0, 1'b0);
    run_vecs();
    chk_counts("pass", 16'd0, 16'd0);

    // Idle deletion at HIGH_MARK: first idle after term kept, rest deleted
    do_reset();
    add_wr(START_D, START_C, 12, 1'b1);
    add_wr(dword(0), 8'h00, 12, 1'b1);
    add_wr(dword(1), 8'h00, 12, 1'b1);
    add_wr(TERM_D, TERM_C, 12, 1'b0);
    add_wr(IDLE_D, 8'hff, 12, 1'b0);
    for (int i = 0; i < 4; i++) add_dr(IDLE_D, 8'hff, 12, 1'b0);
    run_vecs();
    chk_counts("delete", 16'd4, 16'd0);

    // Mid-frame overflow: truncate, poison after term
    do_reset();
    add_wr(START_D, START_C, 0, 1'b1);
    add_wr(dword(0), 8'h00, 0, 1'b1);
    for (int i = 1; i < 6; i++) add_dr(dword(i), 8'h00, 15, 1'b0);
    add_dr(TERM_D, TERM_C, 3, 1'b0);
    add_err(IDLE_D, 8'hff, 3);
    add_wr(IDLE_D, 8'hff, 3, 1'b0);
    run_vecs();
    chk_counts("midovf", 16'd0, 16'd1);

    // Start while full: whole frame lost, poison waits for level to drop
    do_reset();
    add_dr(START_D, START_C, 15, 1'b0);
    add_dr(dword(0), 8'h00, 15, 1'b0);
    add_dr(dword(1), 8'h00, 15, 1'b0);
    add_dr(TERM_D, TERM_C, 15, 1'b0);
    add_dr(IDLE_D, 8'hff, 15, 1'b0);
    add_err(IDLE_D, 8'hff, 0);
    add_wr(IDLE_D, 8'hff, 0, 1'b0);
    run_vecs();
    chk_counts("startfull", 16'd0, 16'd1);

    // Start arriving in POISON, back-to-back frames, mark boundaries
    do_reset();
    add_wr(START_D, START_C, 0, 1'b1);
    add_wr(dword(0), 8'h00, 0, 1'b1);
    add_dr(dword(1), 8'h00, 15, 1'b0);
    add_dr(TERM_D, TERM_C, 0, 1'b0);
    add_err(START_D, START_C, 0);
    add_dr(dword(2), 8'h00, 0, 1'b0);
    add_dr(TERM_D, TERM_C, 0, 1'b0);
    add_err(IDLE_D, 8'hff, 0);
    add_wr(START_D, START_C, 12, 1'b1);
    add_wr(TERM_D, TERM_C, 12, 1'b0);
    add_wr(START4_D, START4_C, 12, 1'b1);
    add_wr(TERM_D, TERM_C, 12, 1'b0);
    add_dr(IDLE_D, 8'hff, 15, 1'b0);
    add_wr(IDLE_D, 8'hff, 11, 1'b0);
    add_dr(IDLE_D, 8'hff, 12, 1'b0);
    add_dr(dword(3), 8'h00, 15, 1'b0);
    add_wr(IDLE_D, 8'hff, 0, 1'b0);
    run_vecs();
    chk_counts("b2b", 16'd3, 16'd2);

    // Asynchronous reset mid-frame
    do_reset();
    add_wr(START_D, START_C, 0, 1'b1);
    add_wr(dword(0), 8'h00, 0, 1'b1);
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    vecs.delete();
    @(posedge wr_clk);
    #1;
    chk("pre_rst_in_frame", 64'(in_frame), 64'd1);
    wr_rst = 1'b1;
    #1;
    chk("arst_wr_en",    64'(fifo_wr_en),   64'd0);
    chk("arst_wr_data",  fifo_wr_data,      IDLE_D);
    chk("arst_wr_ctrl",  64'(fifo_wr_ctrl), 64'hff);
    chk("arst_in_frame", 64'(in_frame),     64'd0);
    sb.delete();
    in_data = IDLE_D;
    in_ctrl = 8'hff;
    @(negedge wr_clk);
    wr_rst = 1'b0;
    add_wr(IDLE_D, 8'hff, 0, 1'b0);
    add_wr(START_D, START_C, 0, 1'b1);
    add_wr(TERM_D, TERM_C, 0, 1'b0);
    run_vecs();
    chk_counts("arst", 16'd0, 16'd0);

    // drop_count saturation
    do_reset();
    fifo_level = LW'(14);
    repeat (70000) @(negedge wr_clk);
    chk_counts("sat", 16'hffff, 16'd0);
    repeat (5) @(negedge wr_clk);
    chk("sat_hold_drop_count", 64'(drop_count), 64'hffff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
